// File: rtl/haar_level_extractor.sv
// haar_level_extractor
//   Single-level Haar transform over a frame of DEPTH beats, followed by a
//   QRS-style boundary search on the detail coefficients.
//   Each accepted beat carries 2*N_IN unsigned lanes. The first half sums to A
//   and the second half sums to B. cA = A+B and cD = A-B are stored at wr_ptr.
//   The running cD max/min give F/L. Q is the max of cD just before F, and S is
//   the min of cD just after L. The results are offset and saturated.
// Ports
//   clk, nReset       clock, async active-low reset
//   en                low = synchronous clear of everything (incl. buffer)
//   start             begins a frame from IDLE or DONE
//   in_valid/in_ready beat handshake (ready only while accumulating)
//   in_data           lane k at [k*DW +: DW]
//   rd_addr/rd_data   combinational cA read port, 0 when out of range
//   max_pos/min_pos   cD extremum positions
//   q_begin/s_end     QRS boundaries, q_empty = Q window was empty
//   done              results valid
module haar_level_extractor #(
  parameter int DW    = 16,
  parameter int N_IN  = 4,
  parameter int DEPTH = 100,
  parameter int PW    = 12,
  parameter int QWIN  = 4,
  parameter int SWIN  = 4,
  parameter int QOFF  = 8,
  parameter int SOFF  = 15,
  localparam int CW   = DW + $clog2(2*N_IN) + 1
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   en,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*N_IN*DW-1:0]   in_data,
  input  logic [PW-1:0]          rd_addr,
  output logic signed [CW-1:0]   rd_data,
  output logic [PW-1:0]          max_pos,
  output logic [PW-1:0]          min_pos,
  output logic [PW-1:0]          q_begin,
  output logic [PW-1:0]          s_end,
  output logic                   q_empty,
  output logic                   done
);
  localparam int NL = 2*N_IN;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] D_P  = PW'(DEPTH);
  localparam logic [PW-1:0] DMAX = PW'(DEPTH-1);
  localparam logic [PW-1:0] QW_P = PW'(QWIN);
  localparam logic [PW-1:0] SW_P = PW'(SWIN);
  localparam logic [PW-1:0] QO_P = PW'(QOFF);
  localparam logic [PW:0]   SO_P = (PW+1)'(SOFF);

  typedef enum logic [2:0] {IDLE, ACCUM, SRCH_Q, SRCH_S, DONE} state_t;

  typedef struct packed {
    logic signed [CW-1:0] ca;
    logic signed [CW-1:0] cd;
  } coef_t;

  // All control/result state lives in one record, so that reset and en-clear are one assignment.
  typedef struct packed {
    state_t               state;
    logic [PW-1:0]        wr_ptr, acc_cnt;
    logic                 vld_pipe;
    coef_t                stg;
    logic signed [CW-1:0] max_val, min_val, best_val;
    logic [PW-1:0]        max_pos, min_pos, cnt, best_pos, q_pos, q_begin, s_end;
    logic                 q_emp, q_empty, done;
  } ctl_t;

  ctl_t r;
  logic signed [CW-1:0] ca_mem [DEPTH];
  logic signed [CW-1:0] cd_mem [DEPTH];

  // Per-lane zero extension into the signed coefficient width
  logic [NL-1:0][CW-1:0] lane_ext;
  for (genvar k = 0; k < NL; k++) begin : g_lane
    assign lane_ext[k] = {{(CW-DW){1'b0}}, in_data[k*DW +: DW]};
  end

  logic signed [CW-1:0] a_sum, b_sum;
  coef_t coef_nxt;
  always_comb begin
    a_sum = '0;
    b_sum = '0;
    for (int k = 0; k < N_IN; k++) begin
      a_sum = a_sum + $signed(lane_ext[k]);
      b_sum = b_sum + $signed(lane_ext[N_IN+k]);
    end
    coef_nxt.ca = a_sum + b_sum;
    coef_nxt.cd = a_sum - b_sum;
  end

  logic accept, first;
  assign in_ready = en && (r.state == ACCUM) && (r.acc_cnt < D_P);
  assign accept   = in_valid && in_ready;
  assign first    = (r.wr_ptr == '0);

  // Search windows derived from the settled extremum positions
  logic [PW-1:0] f_pos, l_pos, q_lo, q_last, s_room, s_span, s_last, scan_idx, pick_pos, s_fin;
  logic signed [CW-1:0] cd_cur, pick_val;
  logic [PW:0]   s_sum;
  logic [PW-1:0] s_sat, q_beg_nxt;
  logic          take;

  assign f_pos  = (r.max_pos < r.min_pos) ? r.max_pos : r.min_pos;
  assign l_pos  = (r.max_pos < r.min_pos) ? r.min_pos : r.max_pos;
  assign q_lo   = (f_pos >= QW_P) ? f_pos - QW_P : '0;
  // An empty Q window still occupies one cycle.
  assign q_last = (f_pos == '0) ? '0 : f_pos - q_lo - PW'(1);
  assign s_room = DMAX - l_pos;
  assign s_span = (s_room < SW_P) ? s_room : SW_P;
  assign s_last = (s_room == '0) ? '0 : s_span - PW'(1);

  assign scan_idx = (r.state == SRCH_S) ? l_pos + PW'(1) + r.cnt : q_lo + r.cnt;
  assign cd_cur   = (scan_idx < D_P) ? cd_mem[AW'(scan_idx)] : '0;
  // cnt==0 seeds the best; afterwards only strict improvement replaces, so the earliest index wins ties.
  assign take     = (r.cnt == '0) ||
                    ((r.state == SRCH_S) ? (cd_cur < $signed(r.best_val))
                                         : (cd_cur > $signed(r.best_val)));
  assign pick_pos = take ? scan_idx : r.best_pos;
  assign pick_val = take ? cd_cur : $signed(r.best_val);

  assign s_fin     = (l_pos == DMAX) ? l_pos : pick_pos;
  assign s_sum     = {1'b0, s_fin} + SO_P;
  assign s_sat     = (s_sum > {1'b0, DMAX}) ? DMAX : s_sum[PW-1:0];
  assign q_beg_nxt = (r.q_pos >= QO_P) ? r.q_pos - QO_P : '0;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r <= '0;
    end else if (!en) begin
      r <= '0;
    end else begin
      r.vld_pipe <= 1'b0;
      case (r.state)
        IDLE: if (start) begin
          r.state   <= ACCUM;
          r.wr_ptr  <= '0;
          r.acc_cnt <= '0;
        end
        ACCUM: begin
          r.vld_pipe <= accept;
          if (accept) begin
            r.stg     <= coef_nxt;
            r.acc_cnt <= r.acc_cnt + PW'(1);
          end
          // Extremum tracking happens alongside the buffer write of the staged beat.
          if (r.vld_pipe) begin
            if (first || $signed(r.stg.cd) > $signed(r.max_val)) begin
              r.max_val <= r.stg.cd;
              r.max_pos <= r.wr_ptr;
            end
            if (first || $signed(r.stg.cd) < $signed(r.min_val)) begin
              r.min_val <= r.stg.cd;
              r.min_pos <= r.wr_ptr;
            end
            if (r.wr_ptr == DMAX) begin
              r.state <= SRCH_Q;
              r.cnt   <= '0;
            end else begin
              r.wr_ptr <= r.wr_ptr + PW'(1);
            end
          end
        end
        SRCH_Q: begin
          r.best_val <= pick_val;
          r.best_pos <= pick_pos;
          if (r.cnt == q_last) begin
            r.q_pos <= (f_pos == '0) ? f_pos : pick_pos;
            r.q_emp <= (f_pos == '0);
            r.cnt   <= '0;
            r.state <= SRCH_S;
          end else begin
            r.cnt <= r.cnt + PW'(1);
          end
        end
        SRCH_S: begin
          r.best_val <= pick_val;
          r.best_pos <= pick_pos;
          if (r.cnt == s_last) begin
            r.q_begin <= q_beg_nxt;
            r.s_end   <= s_sat;
            r.q_empty <= r.q_emp;
            r.done    <= 1'b1;
            r.state   <= DONE;
          end else begin
            r.cnt <= r.cnt + PW'(1);
          end
        end
        DONE: if (start) begin
          r.done    <= 1'b0;
          r.q_begin <= '0;
          r.s_end   <= '0;
          r.q_empty <= 1'b0;
          r.max_pos <= '0;
          r.min_pos <= '0;
          r.wr_ptr  <= '0;
          r.acc_cnt <= '0;
          r.state   <= ACCUM;
        end
        default: r.state <= IDLE;
      endcase
    end
  end

  // The coefficient buffer keeps its contents across frames; only reset or en clears it.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ca_mem[i] <= '0;
        cd_mem[i] <= '0;
      end
    end else if (!en) begin
      for (int i = 0; i < DEPTH; i++) begin
        ca_mem[i] <= '0;
        cd_mem[i] <= '0;
      end
    end else if (r.vld_pipe) begin
      ca_mem[AW'(r.wr_ptr)] <= r.stg.ca;
      cd_mem[AW'(r.wr_ptr)] <= r.stg.cd;
    end
  end

  assign rd_data = (rd_addr < D_P) ? ca_mem[AW'(rd_addr)] : '0;
  assign max_pos = r.max_pos;
  assign min_pos = r.min_pos;
  assign q_begin = r.q_begin;
  assign s_end   = r.s_end;
  assign q_empty = r.q_empty;
  assign done    = r.done;
endmodule

// File: tb/tb_haar_level_extractor.sv
// Testbench for haar_level_extractor (N_IN=4, DEPTH=16, QWIN=4, SWIN=4, QOFF=2, SOFF=3).
// Directed table of frames, hand sequences for reset/en/handshake corners,
// and random frames checked against a plain-arithmetic reference model.
module tb_haar_level_extractor;
  localparam int DW = 16, N_IN = 4, DEPTH = 16, PW = 8;
  localparam int QWIN = 4, SWIN = 4, QOFF = 2, SOFF = 3;
  localparam int CW = DW + $clog2(2*N_IN) + 1;
  localparam int NB = 2*N_IN*DW;

  logic clk, nReset, en, start, in_valid, in_ready, q_empty, done;
  logic [NB-1:0] in_data;
  logic [PW-1:0] rd_addr, max_pos, min_pos, q_begin, s_end;
  logic signed [CW-1:0] rd_data;

  haar_level_extractor #(.DW(DW), .N_IN(N_IN), .DEPTH(DEPTH), .PW(PW), .QWIN(QWIN),
                         .SWIN(SWIN), .QOFF(QOFF), .SOFF(SOFF)) dut (
    .clk(clk), .nReset(nReset), .en(en), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .max_pos(max_pos), .min_pos(min_pos), .q_begin(q_begin), .s_end(s_end),
    .q_empty(q_empty), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [NB-1:0] beat_t;
  typedef struct { int max_pos; int min_pos; int q_begin; int s_end; int q_empty; } res_t;
  typedef struct { string name; int kind; res_t exp; } vec_t;

  int    n_run, n_fail;
  beat_t frame [DEPTH];
  int    m_ca  [DEPTH];
  int    m_cd  [DEPTH];
  vec_t  vecs  [3];
  res_t  r_exp;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input int lo_val, input int hi_val);
    beat_t b = '0;
    for (int k = 0; k < N_IN; k++) begin
      b[k*DW +: DW]        = DW'(lo_val);
      b[(N_IN+k)*DW +: DW] = DW'(hi_val);
    end
    return b;
  endfunction

  task automatic build_frame(input int kind);
    for (int i = 0; i < DEPTH; i++) frame[i] = mk(0, 0);
    case (kind)
      0: for (int i = 0; i < DEPTH; i++) frame[i] = mk(1, 1);
      1: begin frame[8] = mk(100, 0); frame[10] = mk(0, 100); end
      2: begin frame[1] = mk(10, 0); frame[3] = mk(0, 50); frame[15] = mk(50, 0); end
      3: for (int i = 0; i < DEPTH; i++) begin
           frame[i][0 +: DW]    = DW'(i + 1);
           frame[i][5*DW +: DW] = DW'((i*7) % 5);
         end
      default: begin
        for (int i = 0; i < DEPTH; i++)
          for (int k = 0; k < 2*N_IN; k++)
            case (kind % 3)
              0:       frame[i][k*DW +: DW] = DW'($urandom_range(0, 3));
              1:       frame[i][k*DW +: DW] = DW'($urandom);
              default: frame[i][k*DW +: DW] = DW'($urandom_range(0, 1));
            endcase
        if (kind % 3 == 2) begin
          frame[$urandom_range(0, DEPTH-1)] = mk(60000, 0);
          frame[$urandom_range(0, DEPTH-1)] = mk(0, 60000);
        end
      end
    endcase
  endtask

  // Reference: coefficients by direct summation, extrema as "first index holding the extreme value".
  task automatic model(output res_t res);
    int mx, mn, mxp, mnp, f, l, lo, hi, qp, sp, best;
    for (int i = 0; i < DEPTH; i++) begin
      int a = 0, b = 0;
      for (int k = 0; k < N_IN; k++) begin
        a += int'(frame[i][k*DW +: DW]);
        b += int'(frame[i][(N_IN+k)*DW +: DW]);
      end
      m_ca[i] = a + b;
      m_cd[i] = a - b;
    end
    mx = m_cd[0]; mn = m_cd[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (m_cd[i] > mx) mx = m_cd[i];
      if (m_cd[i] < mn) mn = m_cd[i];
    end
    mxp = -1; mnp = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mxp < 0 && m_cd[i] == mx) mxp = i;
      if (mnp < 0 && m_cd[i] == mn) mnp = i;
    end
    f = (mxp < mnp) ? mxp : mnp;
    l = (mxp < mnp) ? mnp : mxp;
    res.q_empty = (f == 0);
    if (f == 0) qp = 0;
    else begin
      lo = (f - QWIN < 0) ? 0 : f - QWIN;
      best = m_cd[lo];
      for (int i = lo; i < f; i++) if (m_cd[i] > best) best = m_cd[i];
      qp = -1;
      for (int i = lo; i < f; i++) if (qp < 0 && m_cd[i] == best) qp = i;
    end
    if (l == DEPTH-1) sp = l;
    else begin
      hi = (l + SWIN > DEPTH-1) ? DEPTH-1 : l + SWIN;
      best = m_cd[l+1];
      for (int i = l+1; i <= hi; i++) if (m_cd[i] < best) best = m_cd[i];
      sp = -1;
      for (int i = l+1; i <= hi; i++) if (sp < 0 && m_cd[i] == best) sp = i;
    end
    res.max_pos = mxp;
    res.min_pos = mnp;
    res.q_begin = (qp - QOFF < 0) ? 0 : qp - QOFF;
    res.s_end   = (sp + SOFF > DEPTH-1) ? DEPTH-1 : sp + SOFF;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_frame(input int nb, input bit gaps, input bit poke);
    for (int i = 0; i < nb; i++) begin
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = frame[i];
      start    = poke && (i == 5);
      begin
        int t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
      end
      chk("in_ready_accum", int'(in_ready), 1);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 200) begin @(negedge clk); t++; end
    chk({tag, ".done"}, int'(done), 1);
  endtask

  task automatic check_out(input string tag, input res_t e);
    chk({tag, ".in_ready_low"}, int'(in_ready), 0);
    chk({tag, ".max_pos"}, int'(max_pos), e.max_pos);
    chk({tag, ".min_pos"}, int'(min_pos), e.min_pos);
    chk({tag, ".q_begin"}, int'(q_begin), e.q_begin);
    chk({tag, ".s_end"},   int'(s_end),   e.s_end);
    chk({tag, ".q_empty"}, int'(q_empty), e.q_empty);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk); rd_addr = PW'(a); #1;
      chk({tag, ".cA"}, int'($signed(rd_data)), m_ca[a]);
    end
    rd_addr = PW'(DEPTH + 2); #1;
    chk({tag, ".cA_oob"}, int'($signed(rd_data)), 0);
    chk({tag, ".done_held"}, int'(done), 1);
    rd_addr = '0;
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    nReset = 1'b0; en = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
    vecs[0] = '{"all_ones",   0, '{0, 0, 0, 4, 1}};
    vecs[1] = '{"spike_8_10", 1, '{8, 10, 2, 14, 0}};
    vecs[2] = '{"edge_15_3",  2, '{15, 3, 0, 15, 0}};

    repeat (3) @(negedge clk);
    chk("rst.done", int'(done), 0);
    chk("rst.in_ready", int'(in_ready), 0);
    chk("rst.max_pos", int'(max_pos), 0);
    chk("rst.s_end", int'(s_end), 0);
    nReset = 1'b1;

    // in_valid while IDLE is ignored
    in_valid = 1'b1; in_data = mk(7, 3);
    repeat (3) @(negedge clk);
    chk("idle.in_ready", int'(in_ready), 0);
    #1 chk("idle.cA0", int'($signed(rd_data)), 0);
    in_valid = 1'b0;

    // directed table: first frame from IDLE, later ones restart from DONE
    for (int v = 0; v < 3; v++) begin
      res_t dummy;
      build_frame(vecs[v].kind);
      model(dummy);
      pulse_start();
      send_frame(DEPTH, 1'b0, 1'b0);
      wait_done(vecs[v].name);
      check_out(vecs[v].name, vecs[v].exp);
    end

    // toggling valid, start poked mid-frame, combinational in_ready drop with en
    build_frame(3);
    model(r_exp);
    pulse_start();
    en = 1'b0; #1;
    chk("en_comb.in_ready", int'(in_ready), 0);
    en = 1'b1; #1;
    chk("en_comb.in_ready_back", int'(in_ready), 1);
    send_frame(DEPTH, 1'b1, 1'b1);
    wait_done("toggle");
    check_out("toggle", r_exp);

    // reset mid-frame discards it
    build_frame(4);
    pulse_start();
    send_frame(8, 1'b0, 1'b0);
    nReset = 1'b0; #1;
    chk("midrst.done", int'(done), 0);
    chk("midrst.in_ready", int'(in_ready), 0);
    chk("midrst.max_pos", int'(max_pos), 0);
    chk("midrst.min_pos", int'(min_pos), 0);
    chk("midrst.q_empty", int'(q_empty), 0);
    rd_addr = 3; #1;
    chk("midrst.cA3", int'($signed(rd_data)), 0);
    rd_addr = 0;
    @(negedge clk); nReset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst.idle_wait", int'(in_ready), 0);
    build_frame(1);
    model(r_exp);
    pulse_start();
    send_frame(DEPTH, 1'b0, 1'b0);
    wait_done("after_rst");
    check_out("after_rst", r_exp);

    // en dropped in DONE clears results and buffer
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    chk("en_clr.done", int'(done), 0);
    chk("en_clr.max_pos", int'(max_pos), 0);
    chk("en_clr.min_pos", int'(min_pos), 0);
    chk("en_clr.s_end", int'(s_end), 0);
    en = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk); rd_addr = PW'(a); #1;
      chk("en_clr.cA", int'($signed(rd_data)), 0);
    end

    // randomized frames against the model
    for (int n = 0; n < 6; n++) begin
      build_frame(4 + n);
      model(r_exp);
      pulse_start();
      send_frame(DEPTH, n[0], 1'b0);
      wait_done("rand");
      check_out("rand", r_exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
